// File: rtl/instruction_decode_stage_if.sv
// Fetch-side and execute-side handshake bundle for the decode stage.
// master = decode stage, slave = the fetch/execute environment around it.
interface instruction_decode_stage_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [31:0]     in_instr;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_rs1_data;
    logic [XLEN-1:0] out_rs2_data;
    logic [XLEN-1:0] out_imm;
    logic [4:0]      out_rd;
    logic [2:0]      out_funct3;
    logic            out_funct7b5;
    logic [7:0]      out_ctrl;

    modport master (
        input  in_valid, in_pc, in_instr, out_ready,
        output in_ready, out_valid, out_pc, out_rs1_data, out_rs2_data, out_imm,
               out_rd, out_funct3, out_funct7b5, out_ctrl
    );

    modport slave (
        output in_valid, in_pc, in_instr, out_ready,
        input  in_ready, out_valid, out_pc, out_rs1_data, out_rs2_data, out_imm,
               out_rd, out_funct3, out_funct7b5, out_ctrl
    );
endinterface

// File: rtl/instruction_decode_stage.sv
// RV32I decode stage: register file read with writeback bypass, immediate and control
// generation, and a single valid/ready output pipeline register toward execute.
module instruction_decode_stage #(
    parameter int unsigned XLEN      = 32,
    parameter bit          BYPASS_WB = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    instruction_decode_stage_if.master io_bus,
    input  logic                       i_flush,
    input  logic                       i_wb_en,
    input  logic [4:0]                 i_wb_rd,
    input  logic [XLEN-1:0]            i_wb_data
);
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;

    logic [XLEN-1:0]    r_regs [32];

    logic               r_valid;
    logic [XLEN-1:0]    r_pc;
    logic [XLEN-1:0]    r_rs1_data;
    logic [XLEN-1:0]    r_rs2_data;
    logic [XLEN-1:0]    r_imm;
    logic [4:0]         r_rd;
    logic [2:0]         r_funct3;
    logic               r_funct7b5;
    logic [7:0]         r_ctrl;

    logic [31:0]        w_instr;
    logic [6:0]         w_opcode;
    logic [4:0]         w_rd;
    logic [4:0]         w_rs1;
    logic [4:0]         w_rs2;
    logic               w_in_ready;
    logic               w_accept;
    logic [XLEN-1:0]    w_rs1_data;
    logic [XLEN-1:0]    w_rs2_data;
    logic signed [31:0] w_imm32;
    logic [XLEN-1:0]    w_imm;
    logic               w_illegal;
    logic               w_reg_write;
    logic               w_alu_src_imm;
    logic               w_mem_read;
    logic               w_mem_write;
    logic               w_branch;
    logic               w_jump;
    logic               w_pc_rel;
    logic [7:0]         w_ctrl;

    assign w_instr    = io_bus.in_instr;
    assign w_opcode   = w_instr[6:0];
    assign w_rd       = w_instr[11:7];
    assign w_rs1      = w_instr[19:15];
    assign w_rs2      = w_instr[24:20];

    assign w_in_ready = !r_valid || io_bus.out_ready;
    assign w_accept   = io_bus.in_valid && w_in_ready && !i_flush;

    // x0 is hardwired; a same-cycle writeback wins over the stored value when bypass is on.
    always_comb begin
        w_rs1_data = r_regs[w_rs1];
        if (w_rs1 == 5'd0) begin
            w_rs1_data = '0;
        end else if (BYPASS_WB && i_wb_en && (i_wb_rd == w_rs1)) begin
            w_rs1_data = i_wb_data;
        end
        w_rs2_data = r_regs[w_rs2];
        if (w_rs2 == 5'd0) begin
            w_rs2_data = '0;
        end else if (BYPASS_WB && i_wb_en && (i_wb_rd == w_rs2)) begin
            w_rs2_data = i_wb_data;
        end
    end

    always_comb begin
        w_illegal     = 1'b0;
        w_reg_write   = 1'b0;
        w_alu_src_imm = 1'b0;
        w_mem_read    = 1'b0;
        w_mem_write   = 1'b0;
        w_branch      = 1'b0;
        w_jump        = 1'b0;
        w_pc_rel      = 1'b0;
        w_imm32       = '0;
        case (w_opcode)
            OpReg: begin
                w_reg_write = 1'b1;
            end
            OpImm: begin
                w_reg_write   = 1'b1;
                w_alu_src_imm = 1'b1;
                w_imm32       = {{20{w_instr[31]}}, w_instr[31:20]};
            end
            OpLoad: begin
                w_reg_write   = 1'b1;
                w_alu_src_imm = 1'b1;
                w_mem_read    = 1'b1;
                w_imm32       = {{20{w_instr[31]}}, w_instr[31:20]};
            end
            OpStore: begin
                w_alu_src_imm = 1'b1;
                w_mem_write   = 1'b1;
                w_imm32       = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
            end
            OpBranch: begin
                w_branch = 1'b1;
                w_pc_rel = 1'b1;
                w_imm32  = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25],
                            w_instr[11:8], 1'b0};
            end
            OpJal: begin
                w_reg_write = 1'b1;
                w_jump      = 1'b1;
                w_pc_rel    = 1'b1;
                w_imm32     = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20],
                               w_instr[30:21], 1'b0};
            end
            OpJalr: begin
                w_reg_write   = 1'b1;
                w_jump        = 1'b1;
                w_alu_src_imm = 1'b1;
                w_imm32       = {{20{w_instr[31]}}, w_instr[31:20]};
            end
            OpLui: begin
                w_reg_write   = 1'b1;
                w_alu_src_imm = 1'b1;
                w_imm32       = {w_instr[31:12], 12'b0};
            end
            OpAuipc: begin
                w_reg_write   = 1'b1;
                w_alu_src_imm = 1'b1;
                w_pc_rel      = 1'b1;
                w_imm32       = {w_instr[31:12], 12'b0};
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    // Signed source makes the size cast sign-extend when XLEN > 32.
    assign w_imm  = XLEN'(w_imm32);
    assign w_ctrl = {w_illegal, w_reg_write && (w_rd != 5'd0), w_alu_src_imm, w_mem_read,
                     w_mem_write, w_branch, w_jump, w_pc_rel};

    // Writeback is independent of flush and of the output handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_wb_en && (i_wb_rd != 5'd0)) begin
            r_regs[i_wb_rd] <= i_wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_rd       <= '0;
            r_funct3   <= '0;
            r_funct7b5 <= 1'b0;
            r_ctrl     <= '0;
        end else if (w_accept) begin
            r_valid    <= 1'b1;
            r_pc       <= io_bus.in_pc;
            r_rs1_data <= w_rs1_data;
            r_rs2_data <= w_rs2_data;
            r_imm      <= w_imm;
            r_rd       <= w_rd;
            r_funct3   <= w_instr[14:12];
            r_funct7b5 <= w_instr[30];
            r_ctrl     <= w_ctrl;
        end else if (i_flush || io_bus.out_ready) begin
            // Data fields deliberately keep their last values.
            r_valid <= 1'b0;
        end
    end

    assign io_bus.in_ready     = w_in_ready;
    assign io_bus.out_valid    = r_valid;
    assign io_bus.out_pc       = r_pc;
    assign io_bus.out_rs1_data = r_rs1_data;
    assign io_bus.out_rs2_data = r_rs2_data;
    assign io_bus.out_imm      = r_imm;
    assign io_bus.out_rd       = r_rd;
    assign io_bus.out_funct3   = r_funct3;
    assign io_bus.out_funct7b5 = r_funct7b5;
    assign io_bus.out_ctrl     = r_ctrl;
endmodule

// File: tb/tb_instruction_decode_stage.sv
// Bench for instruction_decode_stage: directed scenarios plus random traffic, checked by a
// queue-based scoreboard fed from a behavioural decode/register-file model.
module tb_instruction_decode_stage;
    localparam int unsigned XLEN = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    instruction_decode_stage_if #(.XLEN(XLEN)) bus ();

    instruction_decode_stage #(
        .XLEN      (XLEN),
        .BYPASS_WB (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .io_bus    (bus),
        .i_flush   (flush),
        .i_wb_en   (wb_en),
        .i_wb_rd   (wb_rd),
        .i_wb_data (wb_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        f7b5;
        logic [7:0]  ctrl;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mregs [32];
    logic        m_valid;
    logic        p_acc;
    exp_t        last_seen;
    exp_t        cur;
    logic        exp_v;
    logic [31:0] pc_cnt;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] operand(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        if (wb_en && wb_rd == r) return wb_data;
        return mregs[r];
    endfunction

    // Reference decode: immediates assembled arithmetically from shifted fields.
    function automatic exp_t predict(input logic [31:0] pc, input logic [31:0] ins,
                                     input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [31:0] sx;
        logic        ill, rw, ai, mr, mw, br, jp, pr;
        sx  = ins[31] ? 32'hFFFF_FFFF : 32'h0;
        ill = 0; rw = 0; ai = 0; mr = 0; mw = 0; br = 0; jp = 0; pr = 0;
        e.imm = 32'd0;
        case (ins[6:0])
            7'b0110011: rw = 1;
            7'b0010011: begin rw = 1; ai = 1; e.imm = (sx << 12) | (ins >> 20); end
            7'b0000011: begin rw = 1; ai = 1; mr = 1; e.imm = (sx << 12) | (ins >> 20); end
            7'b0100011: begin
                ai = 1; mw = 1;
                e.imm = (sx << 12) | ((ins >> 25) << 5) | ((ins >> 7) & 32'd31);
            end
            7'b1100011: begin
                br = 1; pr = 1;
                e.imm = (sx << 12) | (((ins >> 7) & 32'd1) << 11) | (((ins >> 25) & 32'd63) << 5)
                      | (((ins >> 8) & 32'd15) << 1);
            end
            7'b1101111: begin
                rw = 1; jp = 1; pr = 1;
                e.imm = (sx << 20) | (ins & 32'h000F_F000) | (((ins >> 20) & 32'd1) << 11)
                      | (((ins >> 21) & 32'd1023) << 1);
            end
            7'b1100111: begin rw = 1; jp = 1; ai = 1; e.imm = (sx << 12) | (ins >> 20); end
            7'b0110111: begin rw = 1; ai = 1; e.imm = ins & 32'hFFFF_F000; end
            7'b0010111: begin rw = 1; ai = 1; pr = 1; e.imm = ins & 32'hFFFF_F000; end
            default:    ill = 1;
        endcase
        if (ins[11:7] == 5'd0) rw = 0;
        e.pc   = pc;
        e.rs1  = a;
        e.rs2  = b;
        e.rd   = ins[11:7];
        e.f3   = ins[14:12];
        e.f7b5 = ins[30];
        e.ctrl = {ill, rw, ai, mr, mw, br, jp, pr};
        return e;
    endfunction

    // Stimulus-side predictor: pushes the expected decode for every instruction accepted.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_valid = 1'b0;
            for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        end else begin
            p_acc = bus.in_valid && (!m_valid || bus.out_ready) && !flush;
            if (flush) begin
                q.delete();
                m_valid = 1'b0;
            end else if (p_acc) begin
                q.push_back(predict(bus.in_pc, bus.in_instr, operand(bus.in_instr[19:15]),
                                    operand(bus.in_instr[24:20])));
                m_valid = 1'b1;
            end else if (bus.out_ready) begin
                m_valid = 1'b0;
            end
            if (wb_en && wb_rd != 5'd0) mregs[wb_rd] = wb_data;
        end
    end

    // Monitor: compares what the DUT presents against the scoreboard head.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_seen = '0;
        end else begin
            exp_v = (q.size() != 0);
            check("out_valid", 64'(bus.out_valid), 64'(exp_v));
            check("in_ready", 64'(bus.in_ready), 64'(!exp_v || bus.out_ready));
            cur = exp_v ? q[0] : last_seen;
            check("out_pc", 64'(bus.out_pc), 64'(cur.pc));
            check("out_rs1_data", 64'(bus.out_rs1_data), 64'(cur.rs1));
            check("out_rs2_data", 64'(bus.out_rs2_data), 64'(cur.rs2));
            check("out_imm", 64'(bus.out_imm), 64'(cur.imm));
            check("out_rd", 64'(bus.out_rd), 64'(cur.rd));
            check("out_funct3", 64'(bus.out_funct3), 64'(cur.f3));
            check("out_funct7b5", 64'(bus.out_funct7b5), 64'(cur.f7b5));
            check("out_ctrl", 64'(bus.out_ctrl), 64'(cur.ctrl));
            if (exp_v) begin
                last_seen = q[0];
                if (bus.out_ready) void'(q.pop_front());
            end
        end
    end

    task automatic drive(input logic v, input logic [31:0] ins, input logic ordy,
                         input logic fl, input logic we, input logic [4:0] rd,
                         input logic [31:0] wd);
        bus.in_valid  = v;
        bus.in_pc     = pc_cnt;
        bus.in_instr  = ins;
        bus.out_ready = ordy;
        flush         = fl;
        wb_en         = we;
        wb_rd         = rd;
        wb_data       = wd;
        pc_cnt        = pc_cnt + 32'd4;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic ordy);
        drive(1'b0, 32'd0, ordy, 1'b0, 1'b0, 5'd0, 32'd0);
    endtask

    logic [6:0]  ops [9];
    logic [31:0] rnd;

    initial begin
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
        pc_cnt        = 32'h0000_1000;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_pc     = 32'd0;
        bus.in_instr  = 32'd0;
        bus.out_ready = 1'b0;
        flush         = 1'b0;
        wb_en         = 1'b0;
        wb_rd         = 5'd0;
        wb_data       = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1'b1);

        // Basic add through the register file.
        drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 5'd1, 32'd5);
        drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 5'd2, 32'd7);
        drive(1'b1, 32'h0020_81B3, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        check("t1_rs1", 64'(bus.out_rs1_data), 64'd5);
        check("t1_rs2", 64'(bus.out_rs2_data), 64'd7);
        check("t1_rd", 64'(bus.out_rd), 64'd3);
        check("t1_ctrl", 64'(bus.out_ctrl), 64'h40);
        idle(1'b1);

        // Same-cycle writeback bypass.
        drive(1'b1, 32'h0020_81B3, 1'b1, 1'b0, 1'b1, 5'd1, 32'hDEAD_BEEF);
        check("t2_bypass", 64'(bus.out_rs1_data), 64'hDEAD_BEEF);
        idle(1'b1);

        // Stall for three cycles with a pending instruction.
        drive(1'b1, 32'h0020_81B3, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h0011_0233, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
            check("t3_in_ready_stall", 64'(bus.in_ready), 64'd0);
        end
        drive(1'b1, 32'h0011_0233, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        check("t3_next_rd", 64'(bus.out_rd), 64'd4);
        idle(1'b1);

        // Branch immediate and illegal opcode.
        drive(1'b1, 32'hFE00_0EE3, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        check("t4_br_imm", 64'(bus.out_imm), 64'hFFFF_FFFC);
        check("t4_br_ctrl", 64'(bus.out_ctrl), 64'h05);
        drive(1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        check("t4_ill_ctrl", 64'(bus.out_ctrl), 64'h80);
        check("t4_ill_valid", 64'(bus.out_valid), 64'd1);
        idle(1'b1);

        // Flush kills the held and the incoming instruction.
        drive(1'b1, 32'h0020_81B3, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        drive(1'b1, 32'h0011_0233, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
        check("t5_flush_valid", 64'(bus.out_valid), 64'd0);
        idle(1'b1);
        check("t5_flush_nothing", 64'(bus.out_valid), 64'd0);

        // x0 writes are ignored; reset mid-stall clears output and register file.
        drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 5'd0, 32'h1234);
        drive(1'b1, 32'h0000_02B3, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        check("t6_x0", 64'(bus.out_rs1_data), 64'd0);
        drive(1'b1, 32'h0020_81B3, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        idle(1'b0);
        rst_n = 1'b0;
        #1;
        check("t6_async_reset", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 32'h0020_81B3, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        check("t6_rs1_after_reset", 64'(bus.out_rs1_data), 64'd0);
        check("t6_rs2_after_reset", 64'(bus.out_rs2_data), 64'd0);
        idle(1'b1);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            rnd = $urandom;
            if ($urandom_range(0, 7) != 0) rnd[6:0] = ops[$urandom_range(0, 8)];
            drive($urandom_range(0, 3) != 0, rnd, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 15) == 0, 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 31)), $urandom);
        end
        repeat (3) idle(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
